// File: rtl/slt_alu_pkg.sv
// Shared types and the compare/arithmetic function for the SLT/ALU arbiter.
//   op_t      : 2-bit opcode (SLT, SLTU, ADD, SUB)
//   slot_t    : occupancy of the single result register
//   alu_eval  : width-agnostic evaluation of one opcode (w <= 64)
package slt_alu_pkg;

  localparam int unsigned DEFAULT_WIDTH = 16;

  typedef enum logic [1:0] {
    OP_SLT  = 2'b00,
    OP_SLTU = 2'b01,
    OP_ADD  = 2'b10,
    OP_SUB  = 2'b11
  } op_t;

  typedef enum logic {
    SLOT_EMPTY = 1'b0,
    SLOT_FULL  = 1'b1
  } slot_t;

  // Operands are carried in 64 bits and masked to w bits, so one function
  // serves every WIDTH. Signed compare flips the sign bit and then compares
  // unsigned, which orders two's-complement values correctly.
  function automatic logic [63:0] alu_eval(op_t op, logic [63:0] a, logic [63:0] b,
                                           int unsigned w);
    logic [63:0] mask;
    logic [63:0] sbit;
    logic [63:0] am;
    logic [63:0] bm;
    mask = (w >= 64) ? '1 : ((64'd1 << w) - 64'd1);
    sbit = 64'd1 << (w - 1);
    am   = a & mask;
    bm   = b & mask;
    case (op)
      OP_SLT:  alu_eval = {63'd0, ((am ^ sbit) < (bm ^ sbit))};
      OP_SLTU: alu_eval = {63'd0, (am < bm)};
      OP_ADD:  alu_eval = (am + bm) & mask;
      OP_SUB:  alu_eval = (am - bm) & mask;
      default: alu_eval = '0;
    endcase
  endfunction

endpackage

// File: rtl/slt_alu_arbiter_rr_pick.sv
// Combinational round-robin selector.
//   req : request vector
//   ptr : index with the highest priority this cycle
//   gnt : one-hot grant (zero when no request)
//   idx : encoded index of the granted requester
//   any : at least one request present
module rr_pick #(
  parameter int unsigned N   = 2,
  parameter int unsigned IDW = $clog2(N)
) (
  input  logic [N-1:0]   req,
  input  logic [IDW-1:0] ptr,
  output logic [N-1:0]   gnt,
  output logic [IDW-1:0] idx,
  output logic           any
);

  int unsigned pos;

  // Search upward from ptr with wrap-around; the first hit wins.
  always_comb begin
    gnt = '0;
    idx = '0;
    any = 1'b0;
    pos = 0;
    for (int unsigned i = 0; i < N; i++) begin
      pos = (32'(ptr) + i) % N;
      if (!any && req[pos]) begin
        any      = 1'b1;
        gnt[pos] = 1'b1;
        idx      = IDW'(pos);
      end
    end
  end

endmodule

// File: rtl/slt_alu_arbiter.sv
// Round-robin arbiter sharing one registered SLT/SLTU/ADD/SUB unit.
//   clk, reset_n          : clock, asynchronous active-low reset
//   req_valid/req_ready   : per-requester handshake (ready is one-hot or zero)
//   req_op/req_a/req_b    : per-requester packed opcode and operands
//   res_valid/res_ready   : result handshake
//   res_data/res_id       : registered result and winning requester index
// WIDTH must not exceed 64.
module slt_alu_arbiter
  import slt_alu_pkg::*;
#(
  parameter int unsigned NUM_REQ = 2,
  parameter int unsigned WIDTH   = DEFAULT_WIDTH,
  parameter int unsigned ID_W    = $clog2(NUM_REQ)
) (
  input  logic                     clk,
  input  logic                     reset_n,
  input  logic [NUM_REQ-1:0]       req_valid,
  output logic [NUM_REQ-1:0]       req_ready,
  input  logic [2*NUM_REQ-1:0]     req_op,
  input  logic [WIDTH*NUM_REQ-1:0] req_a,
  input  logic [WIDTH*NUM_REQ-1:0] req_b,
  output logic                     res_valid,
  input  logic                     res_ready,
  output logic [WIDTH-1:0]         res_data,
  output logic [ID_W-1:0]          res_id
);

  slot_t             slot_q, slot_d;
  logic [WIDTH-1:0]  data_q, data_d;
  logic [ID_W-1:0]   id_q, id_d;
  logic [ID_W-1:0]   ptr_q, ptr_d;

  logic              slot_free;
  logic [NUM_REQ-1:0] pick_req;
  logic [NUM_REQ-1:0] pick_gnt;
  logic [ID_W-1:0]   pick_idx;
  logic              pick_any;

  logic [1:0]        sel_op;
  logic [WIDTH-1:0]  sel_a;
  logic [WIDTH-1:0]  sel_b;
  logic [WIDTH-1:0]  alu_res;

  // Masking the requests with reset_n keeps req_ready low while in reset.
  assign slot_free = (slot_q == SLOT_EMPTY) || res_ready;
  assign pick_req  = (slot_free && reset_n) ? req_valid : '0;

  rr_pick #(
    .N   (NUM_REQ),
    .IDW (ID_W)
  ) u_pick (
    .req (pick_req),
    .ptr (ptr_q),
    .gnt (pick_gnt),
    .idx (pick_idx),
    .any (pick_any)
  );

  // Operand mux feeds only the result register, never an output directly.
  always_comb begin
    sel_op = '0;
    sel_a  = '0;
    sel_b  = '0;
    for (int unsigned i = 0; i < NUM_REQ; i++) begin
      if (ID_W'(i) == pick_idx) begin
        sel_op = req_op[2*i +: 2];
        sel_a  = req_a[WIDTH*i +: WIDTH];
        sel_b  = req_b[WIDTH*i +: WIDTH];
      end
    end
    alu_res = WIDTH'(alu_eval(op_t'(sel_op), 64'(sel_a), 64'(sel_b), WIDTH));
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      slot_q <= SLOT_EMPTY;
      data_q <= '0;
      id_q   <= '0;
      ptr_q  <= '0;
    end else begin
      slot_q <= slot_d;
      data_q <= data_d;
      id_q   <= id_d;
      ptr_q  <= ptr_d;
    end
  end

  // A transfer always refills the slot, so accept-plus-grant has no bubble.
  always_comb begin
    slot_d = slot_q;
    data_d = data_q;
    id_d   = id_q;
    ptr_d  = ptr_q;
    if (pick_any) begin
      slot_d = SLOT_FULL;
      data_d = alu_res;
      id_d   = pick_idx;
      ptr_d  = (pick_idx == ID_W'(NUM_REQ - 1)) ? '0 : pick_idx + ID_W'(1);
    end else if (res_ready) begin
      slot_d = SLOT_EMPTY;
    end
  end

  always_comb begin
    req_ready = pick_gnt;
    res_valid = (slot_q == SLOT_FULL);
    res_data  = data_q;
    res_id    = id_q;
  end

endmodule

// File: tb/tb_slt_alu_arbiter.sv
module tb_slt_alu_arbiter;

  localparam int unsigned N  = 2;
  localparam int unsigned W  = 16;
  localparam int unsigned IW = 1;

  logic             clk = 1'b0;
  logic             reset_n;
  logic [N-1:0]     req_valid;
  logic [N-1:0]     req_ready;
  logic [2*N-1:0]   req_op;
  logic [W*N-1:0]   req_a;
  logic [W*N-1:0]   req_b;
  logic             res_valid;
  logic             res_ready;
  logic [W-1:0]     res_data;
  logic [IW-1:0]    res_id;

  always #5 clk = ~clk;

  slt_alu_arbiter #(
    .NUM_REQ (N),
    .WIDTH   (W),
    .ID_W    (IW)
  ) dut (
    .clk       (clk),
    .reset_n   (reset_n),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_op    (req_op),
    .req_a     (req_a),
    .req_b     (req_b),
    .res_valid (res_valid),
    .res_ready (res_ready),
    .res_data  (res_data),
    .res_id    (res_id)
  );

  typedef struct {
    logic [IW-1:0] id;
    logic [W-1:0]  data;
  } exp_t;

  typedef struct {
    int unsigned who;
    logic [1:0]  op;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic [W-1:0] exp;
  } vec_t;

  exp_t        sbq[$];
  vec_t        vecs[10];
  int          checks;
  int          failures;
  logic        m_full;
  int unsigned m_ptr;
  logic [W-1:0] saved;

  function automatic logic [W-1:0] ref_alu(logic [1:0] op, logic [W-1:0] a, logic [W-1:0] b);
    case (op)
      2'b00:   return ($signed(a) < $signed(b)) ? W'(1) : W'(0);
      2'b01:   return (a < b) ? W'(1) : W'(0);
      2'b10:   return a + b;
      default: return a - b;
    endcase
  endfunction

  task automatic check(string name, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic set_req(int unsigned i, logic [1:0] op, logic [W-1:0] a, logic [W-1:0] b);
    req_op[2*i +: 2] = op;
    req_a[W*i +: W]  = a;
    req_b[W*i +: W]  = b;
  endtask

  // One clock cycle: predict the grant, push the expected result, then
  // compare res_valid and pop the scoreboard once the result is registered.
  task automatic step();
    logic [N-1:0] eg;
    int           g;
    logic         free;
    exp_t         e;
    #1;
    eg   = '0;
    g    = -1;
    free = !m_full || res_ready;
    if (free) begin
      for (int unsigned k = 0; k < N; k++) begin
        int unsigned ix;
        ix = (m_ptr + k) % N;
        if (g < 0 && req_valid[ix]) g = int'(ix);
      end
    end
    if (g >= 0) eg[g] = 1'b1;
    check("req_ready", 32'(req_ready), 32'(eg));
    if (g >= 0) begin
      e.id   = IW'(g);
      e.data = ref_alu(req_op[2*g +: 2], req_a[W*g +: W], req_b[W*g +: W]);
      sbq.push_back(e);
    end
    @(posedge clk);
    if (g >= 0) begin
      m_full = 1'b1;
      m_ptr  = (int'(g) + 1) % N;
    end else if (res_ready) begin
      m_full = 1'b0;
    end
    #1;
    check("res_valid", 32'(res_valid), 32'(m_full));
    if (g >= 0) begin
      if (sbq.size() == 0) begin
        check("sb_underflow", 32'(0), 32'(1));
      end else begin
        e = sbq.pop_front();
        check("sb_data", 32'(res_data), 32'(e.data));
        check("sb_id", 32'(res_id), 32'(e.id));
      end
    end
    @(negedge clk);
  endtask

  initial begin
    checks    = 0;
    failures  = 0;
    m_full    = 1'b0;
    m_ptr     = 0;
    req_valid = '0;
    req_op    = '0;
    req_a     = '0;
    req_b     = '0;
    res_ready = 1'b1;

    vecs[0] = '{0, 2'b00, 16'hFFFD, 16'h0005, 16'h0001};
    vecs[1] = '{0, 2'b01, 16'hFFFD, 16'h0005, 16'h0000};
    vecs[2] = '{0, 2'b10, 16'hFFFF, 16'h0002, 16'h0001};
    vecs[3] = '{0, 2'b11, 16'h0000, 16'h0001, 16'hFFFF};
    vecs[4] = '{1, 2'b00, 16'h0005, 16'hFFFD, 16'h0000};
    vecs[5] = '{1, 2'b01, 16'h0005, 16'hFFFD, 16'h0001};
    vecs[6] = '{0, 2'b10, 16'h1234, 16'h1111, 16'h2345};
    vecs[7] = '{1, 2'b11, 16'h8000, 16'h0001, 16'h7FFF};
    vecs[8] = '{0, 2'b00, 16'h8000, 16'h7FFF, 16'h0001};
    vecs[9] = '{1, 2'b00, 16'h7FFF, 16'h7FFF, 16'h0000};

    // Reset with both requesters asking: no grant, all state cleared.
    reset_n = 1'b1;
    #1 reset_n = 1'b0;
    req_valid = 2'b11;
    #11;
    check("rst_req_ready", 32'(req_ready), 32'(0));
    check("rst_res_valid", 32'(res_valid), 32'(0));
    check("rst_res_data", 32'(res_data), 32'(0));
    check("rst_res_id", 32'(res_id), 32'(0));
    @(negedge clk);
    reset_n   = 1'b1;
    req_valid = '0;

    // Single requests from the vector table.
    foreach (vecs[v]) begin
      req_valid = '0;
      set_req(vecs[v].who, vecs[v].op, vecs[v].a, vecs[v].b);
      req_valid[vecs[v].who] = 1'b1;
      res_ready = 1'b1;
      step();
      check("vec_data", 32'(res_data), 32'(vecs[v].exp));
      check("vec_id", 32'(res_id), 32'(vecs[v].who));
    end
    req_valid = '0;

    // Contention: last vector came from req1, so the order starts at 0.
    set_req(0, 2'b10, 16'h0100, 16'h0001);
    set_req(1, 2'b11, 16'h0200, 16'h0001);
    req_valid = 2'b11;
    res_ready = 1'b1;
    for (int c = 0; c < 6; c++) begin
      step();
      check("rr_order", 32'(res_id), 32'(c % 2));
    end
    req_valid = '0;
    step();

    // Backpressure: slot full, req1 waits, then is granted on accept.
    set_req(0, 2'b10, 16'h0ABC, 16'h0001);
    req_valid = 2'b01;
    step();
    saved = res_data;
    check("bp_fill", 32'(saved), 32'(16'h0ABD));
    set_req(1, 2'b11, 16'h0000, 16'h0001);
    req_valid = 2'b10;
    res_ready = 1'b0;
    for (int c = 0; c < 3; c++) begin
      step();
      check("bp_hold", 32'(res_data), 32'(saved));
    end
    res_ready = 1'b1;
    step();
    check("bp_id", 32'(res_id), 32'(1));
    check("bp_data", 32'(res_data), 32'(16'hFFFF));
    req_valid = '0;
    step();

    // Withdrawal: req1 drops valid while blocked and never produces a result.
    req_valid = 2'b01;
    step();
    req_valid = 2'b10;
    res_ready = 1'b0;
    step();
    step();
    req_valid = '0;
    res_ready = 1'b1;
    for (int c = 0; c < 3; c++) step();
    check("wd_valid", 32'(res_valid), 32'(0));
    check("wd_id", 32'(res_id), 32'(0));

    // Reset while the slot is full aborts everything and rewinds rr_ptr.
    req_valid = 2'b01;
    res_ready = 1'b0;
    step();
    reset_n = 1'b0;
    #1;
    check("mid_rst_valid", 32'(res_valid), 32'(0));
    check("mid_rst_data", 32'(res_data), 32'(0));
    check("mid_rst_ready", 32'(req_ready), 32'(0));
    m_full = 1'b0;
    m_ptr  = 0;
    @(negedge clk);
    reset_n   = 1'b1;
    req_valid = 2'b11;
    res_ready = 1'b1;
    step();
    check("post_rst_id", 32'(res_id), 32'(0));
    req_valid = '0;
    step();

    check("sb_empty", 32'(sbq.size()), 32'(0));
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
